// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: strobes rows, debounces whole 16-bit frames and emits press/release events.
// One event in flight; scanning stalls in EMIT until the consumer takes it via valid/ready.
module keypad_scan_ctrl #(
  parameter int SETTLE_CYCLES   = 10,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_scan_en,
  input  logic [3:0] i_col,
  output logic [3:0] o_row,
  output logic       o_key_valid,
  input  logic       i_key_ready,
  output logic [3:0] o_key_code,
  output logic       o_key_press,
  output logic       o_multi_key
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int DW = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES + 1) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_MAX     = DW'(DEBOUNCE_FRAMES);
  localparam logic [3:0]    ROW_IDLE    = 4'b1111;
  localparam logic [3:0]    ROW_FIRST   = 4'b1110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_EVAL,
    S_EMIT
  } state_t;

  state_t        r_state;
  logic [1:0]    r_row_idx;
  logic [SW-1:0] r_settle;
  logic [15:0]   r_frame;
  logic [15:0]   r_cand;
  logic [15:0]   r_stable;
  logic [DW-1:0] r_deb_cnt;
  logic          r_held_vld;
  logic [3:0]    r_held_code;
  logic          r_pend;
  logic [3:0]    r_row;
  logic          r_key_valid;
  logic [3:0]    r_key_code;
  logic          r_key_press;
  logic          r_multi_key;

  logic [DW-1:0] w_deb_next;
  logic          w_apply;
  logic [4:0]    w_nkeys;
  logic [3:0]    w_key_idx;
  logic          w_ev_vld;
  logic [3:0]    w_ev_code;
  logic          w_ev_press;
  logic          w_held_vld_nxt;
  logic [3:0]    w_held_code_nxt;
  logic          w_pend_nxt;
  logic          w_multi_nxt;
  logic [3:0]    w_row_next;
  logic [3:0]    w_frame_base;

  assign o_row       = r_row;
  assign o_key_valid = r_key_valid;
  assign o_key_code  = r_key_code;
  assign o_key_press = r_key_press;
  assign o_multi_key = r_multi_key;

  assign w_row_next   = ~(4'b0001 << (r_row_idx + 2'd1));
  assign w_frame_base = {r_row_idx, 2'b00};

  // Debounce count for the frame just completed, saturating at DEB_MAX.
  always_comb begin
    w_deb_next = DW'(1);
    if (r_frame == r_cand) begin
      w_deb_next = (r_deb_cnt == DEB_MAX) ? DEB_MAX : (r_deb_cnt + DW'(1));
    end
  end

  // A pending re-evaluation forces the rules to run again on an unchanged stable frame.
  assign w_apply = (w_deb_next == DEB_MAX) && ((r_frame != r_stable) || r_pend);

  always_comb begin
    w_nkeys   = '0;
    w_key_idx = '0;
    for (int i = 0; i < 16; i++) begin
      w_nkeys = w_nkeys + {4'd0, r_frame[i]};
    end
    for (int i = 15; i >= 0; i--) begin
      if (r_frame[i]) begin
        w_key_idx = 4'(i);
      end
    end
  end

  always_comb begin
    w_ev_vld        = 1'b0;
    w_ev_code       = r_held_code;
    w_ev_press      = 1'b0;
    w_held_vld_nxt  = r_held_vld;
    w_held_code_nxt = r_held_code;
    w_pend_nxt      = 1'b0;
    w_multi_nxt     = (w_nkeys >= 5'd2);
    if (w_nkeys == 5'd1) begin
      if (!r_held_vld) begin
        w_ev_vld        = 1'b1;
        w_ev_code       = w_key_idx;
        w_ev_press      = 1'b1;
        w_held_vld_nxt  = 1'b1;
        w_held_code_nxt = w_key_idx;
      end else if (w_key_idx != r_held_code) begin
        // Release the old key now; the new one is pressed on the next stable evaluation.
        w_ev_vld       = 1'b1;
        w_ev_code      = r_held_code;
        w_ev_press     = 1'b0;
        w_held_vld_nxt = 1'b0;
        w_pend_nxt     = 1'b1;
      end
    end else if ((w_nkeys == 5'd0) && r_held_vld) begin
      w_ev_vld       = 1'b1;
      w_ev_code      = r_held_code;
      w_ev_press     = 1'b0;
      w_held_vld_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_row_idx   <= '0;
      r_settle    <= '0;
      r_frame     <= '0;
      r_cand      <= '0;
      r_stable    <= '0;
      r_deb_cnt   <= '0;
      r_held_vld  <= 1'b0;
      r_held_code <= '0;
      r_pend      <= 1'b0;
      r_row       <= ROW_IDLE;
      r_key_valid <= 1'b0;
      r_key_code  <= '0;
      r_key_press <= 1'b0;
      r_multi_key <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_row <= ROW_IDLE;
          if (i_scan_en) begin
            r_state   <= S_DRIVE;
            r_row_idx <= '0;
            r_settle  <= '0;
            r_row     <= ROW_FIRST;
          end
        end

        S_DRIVE: begin
          if (r_settle == SETTLE_LAST) begin
            r_state <= S_SAMPLE;
          end else begin
            r_settle <= r_settle + SW'(1);
          end
        end

        S_SAMPLE: begin
          r_frame[w_frame_base +: 4] <= ~i_col;
          if (r_row_idx != 2'd3) begin
            r_state   <= S_DRIVE;
            r_row_idx <= r_row_idx + 2'd1;
            r_settle  <= '0;
            r_row     <= w_row_next;
          end else begin
            r_state <= S_EVAL;
            r_row   <= ROW_IDLE;
          end
        end

        S_EVAL: begin
          r_cand    <= r_frame;
          r_deb_cnt <= w_deb_next;
          if (w_apply) begin
            r_stable    <= r_frame;
            r_multi_key <= w_multi_nxt;
            r_held_vld  <= w_held_vld_nxt;
            r_held_code <= w_held_code_nxt;
            r_pend      <= w_pend_nxt;
          end
          if (w_apply && w_ev_vld) begin
            r_state     <= S_EMIT;
            r_key_valid <= 1'b1;
            r_key_code  <= w_ev_code;
            r_key_press <= w_ev_press;
          end else if (i_scan_en) begin
            r_state   <= S_DRIVE;
            r_row_idx <= '0;
            r_settle  <= '0;
            r_row     <= ROW_FIRST;
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_EMIT: begin
          if (i_key_ready) begin
            r_key_valid <= 1'b0;
            if (i_scan_en) begin
              r_state   <= S_DRIVE;
              r_row_idx <= '0;
              r_settle  <= '0;
              r_row     <= ROW_FIRST;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_row   <= ROW_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboard bench for keypad_scan_ctrl: a frame-level key model predicts events, a monitor checks handshakes.
module tb_keypad_scan_ctrl;

  localparam int SETTLE = 10;
  localparam int DEB    = 4;
  localparam int FRAME_CLKS = 4 * (SETTLE + 1) + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scan_en = 1'b0;
  logic       key_ready = 1'b0;
  logic [3:0] col;
  logic [3:0] row;
  logic       valid;
  logic [3:0] code;
  logic       press;
  logic       multi;
  logic [15:0] pressed = '0;

  int errors = 0;
  int checks = 0;
  int ready_mode = 0;
  bit in_reset = 1'b0;

  typedef struct packed {
    logic [3:0] code;
    logic       press;
  } ev_t;
  ev_t exp_q[$];

  logic [15:0] m_hist[$];
  logic [15:0] m_stable;
  logic        m_held_vld;
  logic [3:0]  m_held;
  logic        m_multi;
  logic        m_pend;

  logic       prev_v = 1'b0;
  logic       prev_r = 1'b0;
  logic [3:0] prev_c = '0;
  logic       prev_p = 1'b0;

  always #5 clk = ~clk;

  // Keypad matrix: a closed key pulls its column low while its row is strobed.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row[r] && pressed[4*r+c]) col[c] = 1'b0;
      end
    end
  end

  keypad_scan_ctrl #(.SETTLE_CYCLES(SETTLE), .DEBOUNCE_FRAMES(DEB)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_scan_en   (scan_en),
    .i_col       (col),
    .o_row       (row),
    .o_key_valid (valid),
    .i_key_ready (key_ready),
    .o_key_code  (code),
    .o_key_press (press),
    .o_multi_key (multi)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    exp_q.delete();
    m_stable   = '0;
    m_held_vld = 1'b0;
    m_held     = '0;
    m_multi    = 1'b0;
    m_pend     = 1'b0;
  endtask

  // A frame is stable once the last DEB frames seen are identical.
  task automatic model_frame(input logic [15:0] f, output bit ev);
    bit run;
    int n;
    logic [3:0] k;
    ev = 1'b0;
    m_hist.push_back(f);
    if (m_hist.size() > DEB) void'(m_hist.pop_front());
    run = (m_hist.size() == DEB);
    foreach (m_hist[i]) if (m_hist[i] != f) run = 1'b0;
    if (!run || ((f == m_stable) && !m_pend)) return;
    m_stable = f;
    m_pend   = 1'b0;
    n = $countones(f);
    m_multi = (n >= 2);
    k = '0;
    for (int i = 15; i >= 0; i--) if (f[i]) k = 4'(i);
    if (n == 1) begin
      if (!m_held_vld) begin
        exp_q.push_back('{code: k, press: 1'b1});
        m_held_vld = 1'b1;
        m_held = k;
        ev = 1'b1;
      end else if (k != m_held) begin
        exp_q.push_back('{code: m_held, press: 1'b0});
        m_held_vld = 1'b0;
        m_pend = 1'b1;
        ev = 1'b1;
      end
    end else if (n == 0 && m_held_vld) begin
      exp_q.push_back('{code: m_held, press: 1'b0});
      m_held_vld = 1'b0;
      ev = 1'b1;
    end
  endtask

  task automatic wait_row(input logic [3:0] v);
    int n = 0;
    while (row !== v && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (row !== v) begin
      checks++;
      errors++;
      $display("FAIL row_wait: row=%b never reached %b within 5000 cycles", row, v);
    end
  endtask

  task automatic apply_frames(input logic [15:0] pat, input int n);
    bit ev;
    for (int i = 0; i < n; i++) begin
      pressed = pat;
      wait_row(4'b0111);
      wait_row(4'b1111);
      model_frame(pat, ev);
      @(posedge clk);
      @(negedge clk);
      check("evt_valid_after_eval", {31'd0, valid}, {31'd0, ev});
      check("multi_key", {31'd0, multi}, {31'd0, m_multi});
    end
  endtask

  // Consumer readiness: 0 = always ready, 1 = stalled, 2 = random.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       key_ready = 1'b1;
        1:       key_ready = 1'b0;
        default: key_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      #2;
      if (in_reset || !rst_n) begin
        prev_v = 1'b0;
      end else begin
        if (prev_v && !prev_r) begin
          check("valid_held", {31'd0, valid}, 32'd1);
          check("event_held", {27'd0, code, press}, {27'd0, prev_c, prev_p});
        end
        if (valid) check("row_idle_in_emit", {28'd0, row}, 32'hF);
        if (valid && key_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: code=%0d press=%0d, expected none", code, press);
          end else begin
            e = exp_q.pop_front();
            check("ev_code", {28'd0, code}, {28'd0, e.code});
            check("ev_press", {31'd0, press}, {31'd0, e.press});
          end
        end
        prev_v = valid;
        prev_r = key_ready;
        prev_c = code;
        prev_p = press;
      end
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_row;
    int bad_rows;
    bit saw_valid;
    bit ev;
    logic [15:0] pat;
    int kind;
    int a;
    int b;

    model_reset();
    in_reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    in_reset = 1'b0;
    check("reset_row", {28'd0, row}, 32'hF);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_code", {28'd0, code}, 32'd0);
    check("reset_press", {31'd0, press}, 32'd0);
    check("reset_multi", {31'd0, multi}, 32'd0);
    repeat (3) @(negedge clk);
    check("idle_row_without_scan_en", {28'd0, row}, 32'hF);

    // Idle scan: exact row strobe timing over one full frame.
    scan_en = 1'b1;
    @(negedge clk);
    bad_rows = 0;
    saw_valid = 1'b0;
    for (int k = 0; k < FRAME_CLKS; k++) begin
      exp_row = (k < FRAME_CLKS - 1) ? ~(4'b0001 << (k / (SETTLE + 1))) : 4'b1111;
      if (row !== exp_row) bad_rows++;
      if (valid) saw_valid = 1'b1;
      if (k < FRAME_CLKS - 1) @(negedge clk);
    end
    check("row_sequence_mismatches", bad_rows, 0);
    check("no_event_idle_scan", {31'd0, saw_valid}, 32'd0);
    model_frame(16'h0000, ev);

    // Key 9 press, reported after DEB frames.
    ready_mode = 0;
    apply_frames(16'h0200, 5);

    // Release of key 9 with the consumer stalled.
    ready_mode = 1;
    apply_frames(16'h0000, DEB);
    repeat (20) @(negedge clk);
    check("stalled_valid", {31'd0, valid}, 32'd1);
    check("stalled_row", {28'd0, row}, 32'hF);
    check("stalled_code", {28'd0, code}, 32'd9);
    check("stalled_press", {31'd0, press}, 32'd0);
    ready_mode = 0;
    repeat (3) @(negedge clk);
    check("accepted_valid_low", {31'd0, valid}, 32'd0);

    // Held key 0, then keys 0+5 together, then release both.
    apply_frames(16'h0001, 5);
    apply_frames(16'h0021, 6);
    apply_frames(16'h0000, 5);

    // Chatter on key 3.
    for (int i = 0; i < 10; i++) apply_frames((i % 2 == 0) ? 16'h0008 : 16'h0000, 1);
    apply_frames(16'h0000, 2);

    // Reset while an event waits in EMIT.
    ready_mode = 1;
    apply_frames(16'h0040, DEB);
    repeat (2) @(negedge clk);
    check("emit_before_reset", {31'd0, valid}, 32'd1);
    in_reset = 1'b1;
    rst_n = 1'b0;
    model_reset();
    pressed = 16'h8000;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    in_reset = 1'b0;
    check("post_reset_valid", {31'd0, valid}, 32'd0);
    check("post_reset_row", {28'd0, row}, 32'hF);
    check("post_reset_multi", {31'd0, multi}, 32'd0);
    ready_mode = 0;
    apply_frames(16'h8000, 5);

    // Randomized key activity with random consumer readiness.
    for (int s = 0; s < 30; s++) begin
      kind = $urandom_range(0, 9);
      a = $urandom_range(0, 15);
      b = (a + $urandom_range(1, 15)) % 16;
      pat = '0;
      if (kind >= 3) pat[a] = 1'b1;
      if (kind >= 8) pat[b] = 1'b1;
      ready_mode = ($urandom_range(0, 2) == 0) ? 0 : 2;
      apply_frames(pat, $urandom_range(1, 6));
    end

    ready_mode = 0;
    apply_frames(16'h0000, DEB + 2);
    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
